idma_be_chan_arb: RTL
=====================

Name: idma_be_chan_arb

Overview:
- Shares one iDMA backend between NumChan descriptor frontends, such as several idma_desc64_top instances in the cva6 descriptor system.
- Arbitrates burst requests round-robin and holds the grant stable across backend backpressure.
- Records the channel ID of every issued transfer in an in-order FIFO. The backend's in-order completion pulses are routed back to the originating channel.
- Gives each channel a per-channel idle indication, replacing the global backend-busy view.

Parameters:
- NumChan, 2, number of requesting channels (>=2).
- MaxInFlight, 4, maximum issued-but-uncompleted transfers (>=1); sets the ID FIFO depth.
- burst_req_t, logic, backend request struct type (idma_req_t).
- ChanIdWidth, (NumChan>1 ? $clog2(NumChan) : 1), derived; do not override.
- CntWidth, $clog2(MaxInFlight+1), derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- chan_req_i  in  NumChan x burst_req_t  per-channel burst request
- chan_valid_i  in  NumChan  per-channel request valid
- chan_ready_o  out  NumChan  per-channel request accepted
- chan_tx_complete_o  out  NumChan  one-cycle completion pulse per channel
- chan_idle_o  out  NumChan  channel has zero outstanding transfers
- be_req_o  out  burst_req_t  request to backend
- be_valid_o  out  1  request valid to backend
- be_ready_i  in  1  backend accepts request
- be_tx_complete_i  in  1  backend completion pulse (in order)
- err_o  out  1  sticky: completion received with no outstanding transfer

Behaviour:
- Clock/reset: one clock domain, clk_i. rst_ni is asynchronous, active-low.
- Reset values:
  - be_valid_o=0, chan_ready_o=0, chan_tx_complete_o=0, chan_idle_o=all 1, err_o=0.
  - RR pointer=0, lock=0, FIFO empty, all counters 0.
  - Reset mid-operation discards all tracking. Completions arriving after reset are handled as spurious (err_o set).
- Issue gating: full = (total_cnt == MaxInFlight), evaluated on the registered count. A completion in the same cycle does not unblock issue. When full: be_valid_o=0, chan_ready_o=0.
- Arbitration (combinational, zero latency):
  - When not full and not locked, grant the first valid channel at or after the RR pointer, scanning upward with wrap-around.
  - be_req_o = chan_req_i[grant]. be_valid_o = |chan_valid_i & ~full.
  - chan_ready_o[grant] = be_ready_i & ~full. All other channels see ready 0.
  - When no channel is valid, be_req_o = '0.
- Lock:
  - If be_valid_o & ~be_ready_i, register lock=1 and the grant index. The next cycle uses the locked grant regardless of the RR pointer.
  - Lock clears on handshake.
  - Channels obey valid/ready stability: once valid, they hold request and valid until ready.
- On handshake (be_valid_o & be_ready_i):
  - Push grant ID into the FIFO.
  - Increment total_cnt and chan_cnt[grant].
  - RR pointer = grant+1, wrapping to 0 after NumChan-1.
- On be_tx_complete_i with total_cnt>0:
  - Pop the FIFO head ID.
  - chan_tx_complete_o[head] = 1 in the same cycle (combinational from head).
  - Decrement total_cnt and chan_cnt[head].
- On be_tx_complete_i with total_cnt==0: no pop, no pulse, err_o <= 1. err_o is sticky until reset.
- Simultaneous handshake and completion:
  - Push and pop both occur; total_cnt unchanged.
  - For the same channel, chan_cnt is unchanged. For different channels, one counter increments and the other decrements.
  - The FIFO must support push and pop in one cycle when neither empty nor full.
- chan_idle_o[i] = (chan_cnt[i]==0), registered-count based. It drops the cycle after that channel's handshake.
- Counter widths: CntWidth bits; counters never wrap because issue gating bounds them.
- Assertions:
  - A locked channel keeps chan_valid_i high with chan_req_i stable.
  - total_cnt equals the sum of chan_cnt.
  - FIFO never overflows.

Test Plan:
- Single channel: ch0 issues 3 requests with be_ready_i=1 on each, then 3 completions -> FIFO IDs {0,0,0}; chan_tx_complete_o=2'b01 three times; chan_idle_o[0] low from cycle after first issue until cycle after third completion.
- Both valid continuously, NumChan=2, be_ready_i=1, completions keep pace -> grants alternate 0,1,0,1; completions return in the same order.
- Backpressure: ch1 granted, be_ready_i low 5 cycles while ch0 also asserts valid -> be_req_o stays ch1's request for all 5 cycles; ch1 accepted first, ch0 next.
- MaxInFlight=4: 4 issues with no completion -> be_valid_o=0 and chan_ready_o=0. A completion alone -> next cycle issue resumes. A completion in the full cycle still blocks issue that cycle.
- Same-cycle handshake (ch1) and completion (head ch0) -> total_cnt constant, chan_cnt[0]-1, chan_cnt[1]+1, chan_tx_complete_o=2'b01.
- Spurious completion at reset-idle -> err_o=1 and stays 1, no chan pulse. Assert rst_ni with 2 outstanding -> all idle=1, err_o=0, next completion sets err_o.

Source files
------------

// File: rtl/idma_be_chan_arb.sv
// -----------------------------------------------------------------------------
// idma_be_chan_arb
//
// Shares one iDMA backend between NumChan descriptor frontends. Burst requests
// are arbitrated round-robin, and the grant is held while the backend applies
// backpressure. The channel ID of every issued transfer is queued in order, so
// the backend's in-order completion pulses can be steered back to the channel
// that issued the transfer. Each channel also gets its own idle flag.
//
// Ports:
//   clk_i               clock
//   rst_ni              asynchronous active-low reset
//   chan_req_i          per-channel burst request
//   chan_valid_i        per-channel request valid
//   chan_ready_o        per-channel request accepted (combinational)
//   chan_tx_complete_o  per-channel one-cycle completion pulse (combinational)
//   chan_idle_o         channel has no outstanding transfers
//   be_req_o            request to the backend (combinational)
//   be_valid_o          request valid to the backend (combinational)
//   be_ready_i          backend accepts the request
//   be_tx_complete_i    backend completion pulse (in order)
//   err_o               sticky: a completion arrived with nothing outstanding
// -----------------------------------------------------------------------------
module idma_be_chan_arb #(
    parameter int  NumChan     = 2,
    parameter int  MaxInFlight = 4,
    parameter type burst_req_t = logic,
    parameter int  ChanIdWidth = (NumChan > 1) ? $clog2(NumChan) : 1,
    parameter int  CntWidth    = $clog2(MaxInFlight + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  burst_req_t         chan_req_i [NumChan],
    input  logic [NumChan-1:0] chan_valid_i,
    output logic [NumChan-1:0] chan_ready_o,
    output logic [NumChan-1:0] chan_tx_complete_o,
    output logic [NumChan-1:0] chan_idle_o,
    output burst_req_t         be_req_o,
    output logic               be_valid_o,
    input  logic               be_ready_i,
    input  logic               be_tx_complete_i,
    output logic               err_o
);

    localparam int PtrWidth = (MaxInFlight > 1) ? $clog2(MaxInFlight) : 1;
    localparam logic [CntWidth-1:0]    FullCnt  = CntWidth'(MaxInFlight);
    localparam logic [CntWidth-1:0]    ZeroCnt  = {CntWidth{1'b0}};
    localparam logic [PtrWidth-1:0]    LastPtr  = PtrWidth'(MaxInFlight - 1);
    localparam logic [ChanIdWidth-1:0] LastChan = ChanIdWidth'(NumChan - 1);

    // Advance a FIFO pointer, wrapping after the last slot (depth need not be
    // a power of two).
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        return (ptr == LastPtr) ? {PtrWidth{1'b0}} : ptr + PtrWidth'(1);
    endfunction

    // Arbitration and lock state
    logic [ChanIdWidth-1:0] rr_ptr_r;
    logic                   lock_r;
    logic [ChanIdWidth-1:0] lock_idx_r;

    // In-order ID FIFO and outstanding-transfer bookkeeping
    logic [ChanIdWidth-1:0] fifo_mem_r [MaxInFlight];
    logic [PtrWidth-1:0]    wr_ptr_r;
    logic [PtrWidth-1:0]    rd_ptr_r;
    logic [CntWidth-1:0]    total_cnt_r;
    logic [CntWidth-1:0]    chan_cnt_r [NumChan];
    logic                   err_r;

    logic                   full_s;
    logic                   any_valid_s;
    logic [ChanIdWidth-1:0] grant_s;
    logic                   hs_s;
    logic                   pop_s;
    logic [ChanIdWidth-1:0] head_s;

    // Issue is blocked on the registered count only, so a completion landing
    // in the full cycle cannot let a new request through in that same cycle.
    assign full_s      = (total_cnt_r == FullCnt);
    assign any_valid_s = |chan_valid_i;
    assign be_valid_o  = any_valid_s & ~full_s;
    assign hs_s        = be_valid_o & be_ready_i;
    assign head_s      = fifo_mem_r[rd_ptr_r];
    // total_cnt_r mirrors FIFO occupancy, so a nonzero count means a valid head.
    assign pop_s       = be_tx_complete_i & (total_cnt_r != ZeroCnt);
    assign be_req_o    = any_valid_s ? chan_req_i[grant_s] : '0;
    assign err_o       = err_r;

    // Grant selection: locked index while backpressured, otherwise the first
    // valid channel at or after the round-robin pointer.
    always_comb begin
        logic found;
        int   cand;
        logic hit;
        grant_s = rr_ptr_r;
        found   = 1'b0;
        cand    = 0;
        hit     = 1'b0;
        if (lock_r) begin
            grant_s = lock_idx_r;
        end else begin
            for (int k = 0; k < NumChan; k++) begin
                cand    = (int'(rr_ptr_r) + k) % NumChan;
                hit     = ~found & chan_valid_i[ChanIdWidth'(cand)];
                grant_s = hit ? ChanIdWidth'(cand) : grant_s;
                found   = found | hit;
            end
        end
    end

    // Per-channel ready, completion steering and idle flags.
    always_comb begin
        chan_ready_o       = {NumChan{1'b0}};
        chan_tx_complete_o = {NumChan{1'b0}};
        chan_idle_o        = {NumChan{1'b0}};
        for (int i = 0; i < NumChan; i++) begin
            chan_ready_o[i]       = (grant_s == ChanIdWidth'(i)) & chan_valid_i[i]
                                    & be_ready_i & ~full_s;
            chan_tx_complete_o[i] = pop_s & (head_s == ChanIdWidth'(i));
            chan_idle_o[i]        = (chan_cnt_r[i] == ZeroCnt);
        end
    end

    // Round-robin pointer and grant lock: the lock pins the grant while the
    // backend stalls a valid request; the pointer moves past each accepted one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_r   <= {ChanIdWidth{1'b0}};
            lock_r     <= 1'b0;
            lock_idx_r <= {ChanIdWidth{1'b0}};
        end else if (hs_s) begin
            lock_r   <= 1'b0;
            rr_ptr_r <= (grant_s == LastChan) ? {ChanIdWidth{1'b0}} : grant_s + ChanIdWidth'(1);
        end else if (be_valid_o) begin
            lock_r     <= 1'b1;
            lock_idx_r <= grant_s;
        end
    end

    // ID FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (hs_s) begin
            fifo_mem_r[wr_ptr_r] <= grant_s;
        end
    end

    // ID FIFO pointers; push and pop may happen in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= {PtrWidth{1'b0}};
            rd_ptr_r <= {PtrWidth{1'b0}};
        end else begin
            if (hs_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
        end
    end

    // Outstanding counters and the sticky spurious-completion flag. A push and
    // a pop on the same channel cancel out in that channel's counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            total_cnt_r <= ZeroCnt;
            for (int i = 0; i < NumChan; i++) begin
                chan_cnt_r[i] <= ZeroCnt;
            end
            err_r <= 1'b0;
        end else begin
            total_cnt_r <= total_cnt_r + CntWidth'(hs_s) - CntWidth'(pop_s);
            for (int i = 0; i < NumChan; i++) begin
                chan_cnt_r[i] <= chan_cnt_r[i]
                                 + CntWidth'(hs_s  && (grant_s == ChanIdWidth'(i)))
                                 - CntWidth'(pop_s && (head_s  == ChanIdWidth'(i)));
            end
            err_r <= err_r | (be_tx_complete_i & (total_cnt_r == ZeroCnt));
        end
    end

    // Sum of the per-channel counters, used by the bookkeeping invariant.
    function automatic logic [31:0] cnt_sum();
        logic [31:0] acc;
        acc = 32'd0;
        for (int i = 0; i < NumChan; i++) begin
            acc = acc + 32'(chan_cnt_r[i]);
        end
        return acc;
    endfunction

    // Protocol and bookkeeping invariants.
    a_lock_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lock_r |-> (be_valid_o && (be_req_o == $past(be_req_o))));
    a_cnt_sum: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_sum() == 32'(total_cnt_r));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(hs_s && full_s));

endmodule
